// File: rtl/cache_ctrl_wb.sv
// Write-back, write-allocate controller for a direct-mapped, one-word-per-line cache.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module cache_ctrl_wb #(
    parameter int LINES  = 8,
    parameter int TAG_W  = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);
    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, REFILL} state_t;
    state_t state, state_nx;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];
    logic [LINES-1:0]  valid, dirty;

    logic              req_we;
    logic [31:3]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] rdata_q;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit, ack;

    logic              mem_req_nx, mem_we_nx;
    logic [31:0]       mem_addr_nx;
    logic [DATA_W-1:0] mem_wdata_nx;

    logic unused_bits;
    assign unused_bits = ^cpu_addr[2:0];

    assign idx     = req_addr[IDX_W+2:3];
    assign req_tag = req_addr[31:IDX_W+3];
    assign hit     = valid[idx] && (tag_mem[idx] == req_tag);
    assign ack     = mem_ack && mem_req;

    // Completion is reported combinationally in COMPARE so a hit answers one cycle after accept.
    assign cpu_ready = (state == IDLE) && !reset;
    assign cpu_valid = (state == COMPARE) && hit && !reset;
    assign cpu_rdata = (cpu_valid && !req_we) ? data_mem[idx] : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        mem_req_nx   = mem_req;
        mem_we_nx    = mem_we;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        case (state)
            IDLE: begin
                if (cpu_req) state_nx = COMPARE;
            end
            COMPARE: begin
                if (hit) begin
                    state_nx = IDLE;
                end else if (valid[idx] && dirty[idx]) begin
                    state_nx     = WRITEBACK;
                    mem_req_nx   = 1'b1;
                    mem_we_nx    = 1'b1;
                    mem_addr_nx  = {tag_mem[idx], idx, 3'b000};
                    mem_wdata_nx = data_mem[idx];
                end else begin
                    state_nx    = REFILL;
                    mem_req_nx  = 1'b1;
                    mem_we_nx   = 1'b0;
                    mem_addr_nx = {req_tag, idx, 3'b000};
                end
            end
            WRITEBACK: begin
                if (ack) begin
                    state_nx    = REFILL;
                    mem_we_nx   = 1'b0;
                    mem_addr_nx = {req_tag, idx, 3'b000};
                end
            end
            REFILL: begin
                if (ack) begin
                    state_nx   = COMPARE;
                    mem_req_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= '0;
            dirty     <= '0;
            rdata_q   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req   <= mem_req_nx;
            mem_we    <= mem_we_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_we    <= cpu_we;
                        req_addr  <= cpu_addr[31:3];
                        req_wdata <= cpu_wdata;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_we) begin
                            data_mem[idx] <= req_wdata;
                            dirty[idx]    <= 1'b1;
                        end else begin
                            rdata_q <= data_mem[idx];
                        end
                    end
                end
                WRITEBACK: begin
                    if (ack) dirty[idx] <= 1'b0;
                end
                REFILL: begin
                    if (ack) begin
                        data_mem[idx] <= mem_rdata;
                        tag_mem[idx]  <= req_tag;
                        valid[idx]    <= 1'b1;
                        dirty[idx]    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic refilled;
    logic [15:0] hit_q, miss_q;

    // The re-compare after a refill is neither a hit nor a second miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            refilled <= 1'b0;
            hit_q    <= '0;
            miss_q   <= '0;
        end else begin
            if (state == IDLE && cpu_req) refilled <= 1'b0;
            if (state == REFILL && ack)   refilled <= 1'b1;
            if (state == COMPARE && !refilled) begin
                if (hit) begin
                    if (hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
                end else begin
                    if (miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
                end
            end
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Scoreboard bench for cache_ctrl_wb: directed requests, a latency-programmable memory model,
// and monitors that pop expected CPU completions and memory transactions.
module tb_cache_ctrl_wb;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, cpu_req, cpu_we, mem_ack;
    logic [31:0] cpu_addr, cpu_wdata, mem_rdata;
    logic        cpu_ready, cpu_valid, mem_req, mem_we;
    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic [15:0] hit_cnt, miss_cnt;

    cache_ctrl_wb #(.LINES(8), .TAG_W(26), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; bit [31:0] rdata; } cpu_t;
    typedef struct { bit we; bit [31:0] addr; bit [31:0] wdata; bit [31:0] rdata; int lat; } mem_t;

    cpu_t cpu_q[$];
    mem_t mem_q[$];
    cpu_t ce;
    mem_t cur;

    int cyc = 0;
    int total = 0, bad = 0;
    int done_cnt = 0, valid_cyc = 0, ack_cyc = 0, rise_cyc = 0, txn_cnt = 0;
    int stray_req = 0, stray_done = 0;
    int waitc = 0;
    bit prev_req = 0, prev_ack = 0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CPU completion monitor
    initial forever begin
        @(negedge clk);
        if (cpu_valid === 1'b1) begin
            valid_cyc = cyc;
            done_cnt++;
            if (cpu_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_cpu_valid: got 1 expected 0");
            end else begin
                ce = cpu_q.pop_front();
                if (!ce.we) check("load_rdata", cpu_rdata, ce.rdata);
            end
        end
    end

    // Memory model and transaction monitor
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (reset) begin
                prev_req = 0;
                prev_ack = 0;
                waitc    = 0;
            end else begin
                if (mem_req) begin
                    if (!prev_req || prev_ack) begin
                        txn_cnt++;
                        rise_cyc = cyc;
                        if (mem_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_mem_req: got addr %h we %0d expected none", mem_addr, mem_we);
                            cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
                            cur.rdata = '0; cur.lat = 0;
                        end else begin
                            cur = mem_q.pop_front();
                            check("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                            check("mem_addr", mem_addr, cur.addr);
                            if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                        end
                        waitc = cur.lat;
                    end else begin
                        check("mem_addr_stable", mem_addr, cur.addr);
                    end
                    if (waitc == 0) begin
                        mem_ack   = 1'b1;
                        mem_rdata = cur.rdata;
                        ack_cyc   = cyc;
                    end else begin
                        waitc--;
                    end
                end else if (stray_req != stray_done) begin
                    mem_ack = 1'b1;
                    stray_done++;
                end
                prev_req = mem_req;
                prev_ack = mem_ack;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic mexp(bit we, bit [31:0] a, bit [31:0] wd, bit [31:0] rd, int lat);
        mem_t m;
        m.we = we; m.addr = a; m.wdata = wd; m.rdata = rd; m.lat = lat;
        mem_q.push_back(m);
    endtask

    task automatic issue(bit we, bit [31:0] a, bit [31:0] wd, output int acc, output bit ok);
        ok  = 0;
        acc = cyc;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (cpu_ready === 1'b1) ok = 1;
            else tick();
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got cpu_ready=0 expected 1");
        end else begin
            cpu_we    = we;
            cpu_addr  = a;
            cpu_wdata = wd;
            cpu_req   = 1'b1;
            acc       = cyc;
            tick();
            cpu_req   = 1'b0;
        end
    endtask

    task automatic do_req(bit we, bit [31:0] a, bit [31:0] wd, bit [31:0] rd, output int acc);
        cpu_t c;
        bit   ok;
        int   d0;
        c.we = we; c.rdata = rd;
        cpu_q.push_back(c);
        d0 = done_cnt;
        issue(we, a, wd, acc, ok);
        if (!ok) begin
            void'(cpu_q.pop_back());
        end else begin
            for (int i = 0; i < 300 && done_cnt == d0; i++) tick();
            if (done_cnt == d0) begin
                total++;
                bad++;
                $display("FAIL completion_timeout: got no cpu_valid expected one for addr %h", a);
            end
        end
    endtask

    int acc, t0;
    bit ok;

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick(); tick();
        check("ready_in_reset", {31'd0, cpu_ready}, 32'd0);
        reset = 1'b0;
        tick();
        check("rst_ready", {31'd0, cpu_ready}, 32'd1);
        check("rst_valid", {31'd0, cpu_valid}, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
        check("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);

        // Clean load miss, 3-cycle memory
        mexp(0, 32'h40, 0, 32'hDEADBEEF, 3);
        t0 = txn_cnt;
        do_req(0, 32'h40, 0, 32'hDEADBEEF, acc);
        check("clean_miss_req_rise", rise_cyc - acc, 2);
        check("clean_miss_valid_lat", valid_cyc - ack_cyc, 1);
        check("clean_miss_txns", txn_cnt - t0, 1);
        check("miss_cnt_1", {16'd0, miss_cnt}, STATS ? 32'd1 : 32'd0);

        // Load hit
        t0 = txn_cnt;
        do_req(0, 32'h40, 0, 32'hDEADBEEF, acc);
        check("hit_latency", valid_cyc - acc, 1);
        check("hit_no_mem", txn_cnt - t0, 0);
        check("hit_cnt_1", {16'd0, hit_cnt}, STATS ? 32'd1 : 32'd0);

        // Store hit, then dirty eviction by a new tag at index 0
        do_req(1, 32'h40, 32'h12345678, 0, acc);
        check("store_hit_latency", valid_cyc - acc, 1);
        mexp(1, 32'h40, 32'h12345678, 0, 2);
        mexp(0, 32'h1040, 0, 32'h11110000, 1);
        t0 = txn_cnt;
        do_req(0, 32'h1040, 0, 32'h11110000, acc);
        check("dirty_miss_txns", txn_cnt - t0, 2);

        // Store miss allocates, merges store data, and is written back later
        mexp(0, 32'h80, 0, 32'hAAAA0000, 2);
        do_req(1, 32'h80, 32'hCAFEF00D, 0, acc);
        do_req(0, 32'h80, 0, 32'hCAFEF00D, acc);
        check("store_merge_hit_latency", valid_cyc - acc, 1);
        mexp(1, 32'h80, 32'hCAFEF00D, 0, 1);
        mexp(0, 32'h1040, 0, 32'h11110000, 0);
        do_req(0, 32'h1040, 0, 32'h11110000, acc);

        // Reset while a write-back is outstanding
        mexp(0, 32'h48, 0, 32'h0, 1);
        do_req(1, 32'h48, 32'h55, 0, acc);
        mexp(1, 32'h48, 32'h55, 0, 50);
        issue(0, 32'h1048, 0, acc, ok);
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) tick();
        check("wb_started", {31'd0, mem_req}, 32'd1);
        tick(); tick();
        reset = 1'b1;
        tick();
        check("reset_drops_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_ready_low", {31'd0, cpu_ready}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        t0 = txn_cnt;
        stray_req++;
        repeat (4) tick();
        check("stray_ack_ignored", {31'd0, mem_req}, 32'd0);
        check("stray_ack_no_txn", txn_cnt - t0, 0);
        check("post_reset_hit_cnt", {16'd0, hit_cnt}, 32'd0);

        // Every line misses after reset, zero-wait memory from here on
        mexp(0, 32'h40, 0, 32'h0BADF00D, 0);
        do_req(0, 32'h40, 0, 32'h0BADF00D, acc);
        mexp(0, 32'h48, 0, 32'h00004848, 0);
        do_req(0, 32'h48, 0, 32'h00004848, acc);

        // Zero-wait dirty miss, then reload the evicted address
        do_req(1, 32'h40, 32'h77, 0, acc);
        mexp(1, 32'h40, 32'h77, 0, 0);
        mexp(0, 32'h1040, 0, 32'h99, 0);
        t0 = txn_cnt;
        do_req(0, 32'h1040, 0, 32'h99, acc);
        check("zero_wait_dirty_txns", txn_cnt - t0, 2);
        mexp(0, 32'h40, 0, 32'h77, 0);
        do_req(0, 32'h40, 0, 32'h77, acc);

        check("final_hit_cnt", {16'd0, hit_cnt}, STATS ? 32'd1 : 32'd0);
        check("final_miss_cnt", {16'd0, miss_cnt}, STATS ? 32'd4 : 32'd0);
        repeat (3) tick();
        check("mem_q_drained", mem_q.size(), 0);
        check("cpu_q_drained", cpu_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
